// File: rtl/jeff_74x157_arbiter.sv
// Two-requester round-robin arbiter driving the select/enable of a shared
// jeff_74x157 quad 2:1 mux, with bounded hold and a dead cycle on hand-over.
module jeff_74x157_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic s,
  output logic en
);

  generate
    if (HOLD_MAX < 1 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_param
      $error("jeff_74x157_arbiter: illegal HOLD_MAX/CNT_W combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(HOLD_MAX - 1);

  state_t           r_state, w_next, w_arb;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_last, w_last_nxt;   // 0 = A owned last, 1 = B
  logic             r_gnt_a, r_gnt_b, r_s, r_en;
  logic             w_gnt_a_nxt, w_gnt_b_nxt, w_s_nxt, w_en_nxt;

  // Round-robin pick: on a tie the side that did not own the mux last wins.
  always_comb begin
    w_arb = IDLE;
    if (req_a && req_b) w_arb = r_last ? GRANT_A : GRANT_B;
    else if (req_a)     w_arb = GRANT_A;
    else if (req_b)     w_arb = GRANT_B;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_s     <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_gnt_a <= w_gnt_a_nxt;
      r_gnt_b <= w_gnt_b_nxt;
      r_s     <= w_s_nxt;
      r_en    <= w_en_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_nxt  = r_cnt;
    w_last_nxt = r_last;
    case (r_state)
      IDLE, GAP: w_next = w_arb;
      GRANT_A: begin
        if (r_cnt != CNT_LIM) w_cnt_nxt = r_cnt + 1'b1;
        // Release takes priority over preemption; GAP only if B is waiting.
        if (!req_a)                        w_next = req_b ? GAP : IDLE;
        else if (req_b && r_cnt == CNT_LIM) w_next = GAP;
      end
      GRANT_B: begin
        if (r_cnt != CNT_LIM) w_cnt_nxt = r_cnt + 1'b1;
        if (!req_b)                        w_next = req_a ? GAP : IDLE;
        else if (req_a && r_cnt == CNT_LIM) w_next = GAP;
      end
      default: w_next = IDLE;
    endcase
    if (w_next == GRANT_A && r_state != GRANT_A) begin
      w_cnt_nxt  = '0;
      w_last_nxt = 1'b0;
    end
    if (w_next == GRANT_B && r_state != GRANT_B) begin
      w_cnt_nxt  = '0;
      w_last_nxt = 1'b1;
    end
  end

  // Outputs are decoded from the next state and registered, so s/en never
  // depend combinationally on the request inputs.
  always_comb begin
    w_gnt_a_nxt = (w_next == GRANT_A);
    w_gnt_b_nxt = (w_next == GRANT_B);
    w_en_nxt    = w_gnt_a_nxt | w_gnt_b_nxt;
    w_s_nxt     = r_s;
    if (w_gnt_a_nxt) w_s_nxt = 1'b0;
    if (w_gnt_b_nxt) w_s_nxt = 1'b1;
  end

  assign gnt_a = r_gnt_a;
  assign gnt_b = r_gnt_b;
  assign s     = r_s;
  assign en    = r_en;

endmodule

// File: doc/jeff_74x157_arbiter.md
Name: jeff_74x157_arbiter

Overview:
- Two-requester round-robin arbiter that shares one jeff_74x157 quad 2-to-1 mux.
- Its s and en outputs connect directly to the mux select and enable. Requester A's data goes on mux input a; requester B's data goes on mux input b.
- Grants are held while a requester keeps asking. A bounded hold counter forces a hand-over when the other side is waiting.
- A one-cycle dead gap, with en low, is inserted on every ownership change so the mux output never glitches between owners.

Parameters:
- HOLD_MAX, 4: maximum consecutive grant cycles while the other requester waits. Legal range 1..255.
- CNT_W, 8: hold counter width. Must satisfy 2**CNT_W > HOLD_MAX.

Ports:
- clk    input   1  system clock, all state changes on rising edge
- rst    input   1  synchronous reset, active-high
- req_a  input   1  requester A wants the mux (level, held until done)
- req_b  input   1  requester B wants the mux
- gnt_a  output  1  A owns the mux this cycle
- gnt_b  output  1  B owns the mux this cycle
- s      output  1  mux select to jeff_74x157 .s (0 = a, 1 = b)
- en     output  1  mux enable to jeff_74x157 .en (0 forces y = 0)

Behaviour:
- All outputs are registered; there are no combinational input-to-output paths.
- Reset, sampled at a rising edge with rst=1:
  - state = IDLE, gnt_a = 0, gnt_b = 0, s = 0, en = 0, cnt = 0.
  - last = B, so A wins the first tie.
  - rst overrides every other input, including mid-grant.
- States: IDLE, GRANT_A, GRANT_B, GAP.
- Arbitration function ARB, used in IDLE and GAP:
  - both requesting: go to the requester that is not last.
  - only one requesting: go to that one.
  - none requesting: go to IDLE.
- Entering GRANT_x sets gnt_x = 1, en = 1, s = (x == B), cnt = 0, last = x.
- IDLE: next state = ARB.
  - Latency: req sampled high at edge k gives gnt high in the cycle after edge k.
- GRANT_A (GRANT_B is symmetric):
  - cnt increments each cycle and saturates at HOLD_MAX-1.
  - req_a = 0: go to GAP if req_b = 1, else go to IDLE.
  - req_a = 1, req_b = 1, cnt == HOLD_MAX-1: go to GAP (preempt).
  - req_a = 1, otherwise: stay. The grant is held indefinitely while B is idle.
- GAP:
  - gnt_a = 0, gnt_b = 0, en = 0; s holds its previous value.
  - Lasts exactly one cycle; next state = ARB.
- IDLE outputs: gnt_a = 0, gnt_b = 0, en = 0, s holds.
- Invariants checked every cycle:
  - never gnt_a & gnt_b.
  - en == (gnt_a | gnt_b).
  - gnt_b implies s = 1; gnt_a implies s = 0.
- Boundary cases:
  - Request dropping in the same cycle as preemption: the release path wins; IDLE/GAP is chosen by the other requester's req.
  - HOLD_MAX = 1: a contended grant lasts exactly 1 cycle.
  - Both requests drop together: go to IDLE, with no GAP.
  - A requester that re-requests while the other owns the mux waits for the hold limit or the release.
- Contended steady state with HOLD_MAX = 4: A×4, GAP, B×4, GAP, repeating with period 10.

Test Plan:
1. Reset priority: rst = 1 for 2 cycles with req_a = req_b = 1.
   - During reset: all outputs 0.
   - First cycle after release: gnt_a = 1, en = 1, s = 0.
2. Lone requester: req_a = 1 for 3 cycles, then 0, with req_b = 0.
   - gnt_a high for exactly 3 cycles, starting one cycle after req_a rises.
   - Then IDLE with en = 0. Mux y equals A data (e.g. 4'ha) only while gnt_a = 1.
3. Full contention: req_a = req_b = 1 held for 30 cycles, HOLD_MAX = 4.
   - gnt_a for 4 cycles, en = 0 for 1 cycle, gnt_b (s = 1) for 4 cycles, en = 0 for 1 cycle, repeating.
   - Mux y alternates between A data 4'h3 and B data 4'h7.
4. No preemption without contention: req_a = 1 for 20 cycles, req_b = 0.
   - gnt_a stays 1 for all 20 cycles; cnt saturates at 3; no GAP.
5. Early release with waiting peer: A granted; req_b rises; req_a drops after A's 2nd grant cycle.
   - Exactly one GAP cycle, then gnt_b = 1, s = 1.
   - Same check with HOLD_MAX = 1 under contention: alternating 1-cycle grants.
6. Reset mid-grant: assert rst for 1 cycle while gnt_b = 1.
   - Next cycle: gnt_b = 0, en = 0, s = 0.
   - With both requests held afterwards, A is granted first (last reset to B).
   - Invariant checker runs throughout all scenarios.
